// File: rtl/btn_pkg.sv
// Shared types and helpers for the button debouncer.
package btn_pkg;

    localparam int unsigned CLK_HZ = 27_000_000;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Convert a duration in milliseconds to CLK_HZ cycles.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Multi-flop synchroniser with a configurable reset value.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronises pin and PLL lock, filters bounce with a
// stable-sample counter, and emits a clean level plus press/release strobes.
// Optional feature macro: BTN_LONG_PRESS_EN (adds the long_press_o strobe).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = ms_to_cycles(10),
    parameter int unsigned SYNC_STAGES       = 2,
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned LONG_PRESS_CYCLES = ms_to_cycles(1000)
) (
    input  logic clkin_i,
    input  logic reset_i,
    input  logic lock_i,
    input  logic button_i,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       pin_s;
    logic       btn_s;
    logic       lock_s;

    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (ACTIVE_LOW)
    ) u_pin_sync (
        .clk_i (clkin_i),
        .rst_i (reset_i),
        .d_i   (button_i),
        .q_o   (pin_s)
    );

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk_i (clkin_i),
        .rst_i (reset_i),
        .d_i   (lock_i),
        .q_o   (lock_s)
    );

    // Normalise so that 1 always means pressed.
    assign btn_s = pin_s ^ ACTIVE_LOW;

    // Debounce FSM with registered level and strobes; idle while unlocked.
    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (!lock_s) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                unique case (state_q)
                    RELEASED: begin
                        if (btn_s) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!btn_s) begin
                            state_q <= RELEASED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!btn_s) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (btn_s) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q   <= RELEASED;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level_o = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              long_done_q;
    logic              long_q;
    logic              enter_pressed_c;
    logic              enter_released_c;

    assign enter_pressed_c  = (state_q == PRESS_WAIT) && btn_s && (cnt_q == CNT_MAX);
    assign enter_released_c = (state_q == RELEASE_WAIT) && !btn_s && (cnt_q == CNT_MAX);

    // Hold timer: runs through release bounces, fires once per accepted press.
    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!lock_s || enter_released_c || (state_q == RELEASED)) begin
                hold_q      <= '0;
                long_done_q <= 1'b0;
            end else if (enter_pressed_c) begin
                hold_q      <= '0;
                long_done_q <= 1'b0;
            end else if ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) begin
                if (hold_q == HOLD_MAX) begin
                    if (!long_done_q) begin
                        long_q      <= 1'b1;
                        long_done_q <= 1'b1;
                    end
                end else begin
                    hold_q <= hold_q + HOLD_W'(1);
                end
            end
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule
